// File: rtl/systolic_feeder_ws.sv
// Weight-stationary feeder for a systolic array: loads one broadcast weight, then
// streams activation vectors into the rows with a per-row skew of r cycles.
module systolic_feeder_ws #(
    parameter int WORDWIDTH = 8,
    parameter int ROWS      = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              start_i,
    input  logic [15:0]                       vec_count_i,
    input  logic                              w_valid_i,
    output logic                              w_ready_o,
    input  logic [WORDWIDTH:0]                w_data_i,
    input  logic                              a_valid_i,
    output logic                              a_ready_o,
    input  logic [ROWS*(WORDWIDTH+1)-1:0]     a_data_i,
    output logic                              mode_out_o,
    output logic [WORDWIDTH:0]                w_out_o,
    output logic [ROWS*(WORDWIDTH+1)-1:0]     a_out_o,
    output logic                              busy_o,
    output logic                              done_o
);
    localparam int WW = WORDWIDTH + 1;
    localparam int DW = (ROWS > 2) ? $clog2(ROWS - 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            w_ready_q, w_ready_d;
    logic            a_ready_q, a_ready_d;
    logic            mode_q, mode_d;
    logic [WW-1:0]   w_out_q, w_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            w_fire, a_fire;
    logic [ROWS*WW-1:0] inj;

    // ready registers mirror the current state, so they qualify the handshakes directly
    assign w_fire = w_valid_i & w_ready_q;
    assign a_fire = a_valid_i & a_ready_q;
    assign inj    = a_fire ? a_data_i : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            drain_q   <= '0;
            w_ready_q <= 1'b0;
            a_ready_q <= 1'b0;
            mode_q    <= 1'b1;
            w_out_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            w_ready_q <= w_ready_d;
            a_ready_q <= a_ready_d;
            mode_q    <= mode_d;
            w_out_q   <= w_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD_W;
                    cnt_d   = vec_count_i;
                end
            end
            S_LOAD_W: begin
                if (w_fire) begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_DRAIN;
                        drain_d = DW'(ROWS - 2);
                    end else begin
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                if (a_fire && cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_DRAIN;
                        drain_d = DW'(ROWS - 2);
                    end
                end
            end
            // drain counter runs ROWS-2 down to 0, i.e. ROWS-1 cycles
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_DONE;
                else               drain_d = drain_q - DW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready_d = (state_d == S_LOAD_W);
        a_ready_d = (state_d == S_COMPUTE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        mode_d    = ~w_fire;
        w_out_d   = w_fire ? w_data_i : w_out_q;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [r:0][WW-1:0] pipe_q;
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                pipe_q <= '0;
            end else begin
                pipe_q[0] <= inj[r*WW +: WW];
                for (int k = 1; k <= r; k++) pipe_q[k] <= pipe_q[k-1];
            end
        end
        assign a_out_o[r*WW +: WW] = pipe_q[r];
    end

    assign w_ready_o  = w_ready_q;
    assign a_ready_o  = a_ready_q;
    assign mode_out_o = mode_q;
    assign w_out_o    = w_out_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
endmodule

// File: tb/tb_systolic_feeder_ws.sv
// Scoreboard bench: jobs are scheduled as lists of handshake edges, the expected
// outputs after each edge are derived from that schedule and checked by a monitor.
module tb_systolic_feeder_ws;
    localparam int WORDWIDTH = 8;
    localparam int ROWS      = 4;
    localparam int WW        = WORDWIDTH + 1;
    localparam int AW        = ROWS * WW;

    logic          clk = 1'b0;
    logic          reset, start, w_valid, w_ready, a_valid, a_ready;
    logic          mode_out, busy, done;
    logic [15:0]   vec_count;
    logic [WW-1:0] w_data, w_out;
    logic [AW-1:0] a_data, a_out;

    always #5 clk = ~clk;

    systolic_feeder_ws #(.WORDWIDTH(WORDWIDTH), .ROWS(ROWS)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .vec_count_i(vec_count),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
        .mode_out_o(mode_out), .w_out_o(w_out), .a_out_o(a_out),
        .busy_o(busy), .done_o(done)
    );

    typedef struct packed {
        logic          wr, ar, md, bz, dn;
        logic [WW-1:0] w;
        logic [AW-1:0] a;
    } snap_t;

    snap_t         sbq[$];
    logic [WW-1:0] wq[$];
    int            gapq[$];
    logic [AW-1:0] vecq[$];
    logic [AW-1:0] hist[int];
    logic [WW-1:0] w_hold = '0;
    int            n_checks = 0, n_pass = 0;
    int            ecnt = 0, last_rst = -1;

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    function automatic logic [AW-1:0] rand_vec();
        return AW'({$urandom(), $urandom()});
    endfunction

    always @(negedge clk) begin
        snap_t x;
        if (sbq.size() != 0) begin
            x = sbq.pop_front();
            chk("w_ready",  AW'(w_ready),  AW'(x.wr));
            chk("a_ready",  AW'(a_ready),  AW'(x.ar));
            chk("mode_out", AW'(mode_out), AW'(x.md));
            chk("busy",     AW'(busy),     AW'(x.bz));
            chk("done",     AW'(done),     AW'(x.dn));
            chk("w_out",    AW'(w_out),    AW'(x.w));
            chk("a_out",    a_out,         x.a);
        end
        if (mode_out === 1'b0) begin
            if (wq.size() == 0) chk("weight_beat_unexpected", AW'(mode_out), AW'(1));
            else                chk("weight_value", AW'(w_out), AW'(wq.pop_front()));
        end
    end

    // Records what row 0 receives at this edge and the skewed rows expected after it.
    task automatic tick(input logic rst, input logic acc, input logic wr, input logic ar,
                        input logic md, input logic bz, input logic dn);
        snap_t x;
        int idx;
        reset = rst;
        hist[ecnt] = acc ? a_data : '0;
        if (rst) begin
            last_rst = ecnt;
            w_hold   = '0;
        end
        x.wr = wr; x.ar = ar; x.md = md; x.bz = bz; x.dn = dn; x.w = w_hold; x.a = '0;
        for (int r = 0; r < ROWS; r++) begin
            idx = ecnt - r;
            if (idx > last_rst) x.a[r*WW +: WW] = hist[idx][r*WW +: WW];
        end
        sbq.push_back(x);
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            start = 1'b0; vec_count = 16'($urandom);
            w_valid = 1'($urandom); w_data = WW'($urandom);
            a_valid = 1'($urandom); a_data = rand_vec();
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // n: vec_count, dw: cycles w_valid is withheld, k>0: reset one edge after vector k
    task automatic run_job(input int n, input int dw, input int maxgap, input int k, input int wdi);
        int s, wv_e, last, d, rr, endE, t, ngen, g;
        int acc[$];
        logic [AW-1:0] vec[$];
        logic [WW-1:0] wd;
        logic [AW-1:0] cur;
        logic isacc;
        wd   = (wdi < 0) ? WW'($urandom) : WW'(wdi);
        s    = ecnt;
        wv_e = s + 1 + dw;
        t    = wv_e;
        ngen = (k > 0 && k + 1 < n) ? k + 1 : n;
        for (int i = 0; i < ngen; i++) begin
            g = (gapq.size() != 0) ? gapq.pop_front() : int'($urandom_range(0, maxgap));
            t = t + 1 + g;
            acc.push_back(t);
            vec.push_back((vecq.size() != 0) ? vecq.pop_front() : rand_vec());
        end
        if (n == 0)         last = wv_e;
        else if (ngen == n) last = acc[n-1];
        else                last = 1 << 30;
        d    = last + ROWS - 1;
        rr   = (k > 0) ? acc[k-1] + 1 : -1;
        endE = (k > 0) ? rr : d + 1;
        for (int e = s; e <= endE; e++) begin
            isacc = 1'b0;
            cur   = rand_vec();
            foreach (acc[i]) if (acc[i] == e) begin isacc = 1'b1; cur = vec[i]; end
            if (e == rr) isacc = 1'b0;
            start     = (e == s) || ($urandom_range(0, 3) == 0);
            vec_count = (e == s) ? 16'(n) : 16'($urandom);
            w_valid   = (e == wv_e) ? 1'b1 : (e > s && e < wv_e) ? 1'b0 : 1'($urandom);
            w_data    = (e == wv_e) ? wd : WW'($urandom);
            a_valid   = (acc.size() != 0 && cur == vec[0] && isacc) ? 1'b1
                      : isacc ? 1'b1 : (e > wv_e && e <= last) ? 1'b0 : 1'($urandom);
            if (e == rr) a_valid = 1'($urandom);
            a_data    = cur;
            if (e == rr) begin
                tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end else begin
                if (e == wv_e) begin
                    w_hold = wd;
                    wq.push_back(wd);
                end
                tick(1'b0, isacc, e < wv_e, n > 0 && e >= wv_e && e < last,
                     e != wv_e, e <= d, e == d);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; vec_count = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        // directed job: vectors {1,2,3,4},{5,6,7,8} back-to-back, weight 5
        gapq = '{0, 0};
        vecq = '{{9'd4, 9'd3, 9'd2, 9'd1}, {9'd8, 9'd7, 9'd6, 9'd5}};
        run_job(2, 0, 0, 0, 5);
        idle(2);
        // same job with a bubble between the vectors
        gapq = '{0, 1};
        vecq = '{{9'd4, 9'd3, 9'd2, 9'd1}, {9'd8, 9'd7, 9'd6, 9'd5}};
        run_job(2, 0, 0, 0, 5);
        idle(1);
        run_job(0, 2, 0, 0, -1);
        idle(1);
        run_job(3, 10, 2, 0, -1);
        idle(2);
        run_job(3, 0, 1, 1, -1);
        idle(2);
        run_job(3, 1, 1, 0, -1);
        idle(1);
        run_job(16'hFFFF, 0, 1, 5, -1);
        idle(2);
        for (int j = 0; j < 14; j++) begin
            run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), 0, -1);
            idle(int'($urandom_range(0, 3)));
        end
        idle(3);
        @(negedge clk);
        #1;
        chk("scoreboard_left", AW'(sbq.size()), '0);
        chk("weight_queue_left", AW'(wq.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/systolic_feeder_ws.md
SYSTOLIC_FEEDER_WS -- requirements
Module: systolic_feeder_ws

Interface
- REQ-001: The module SHALL have these parameters: WORDWIDTH, 8, data word width (one data word is WORDWIDTH+1 bits, matching the PE ports); ROWS, 4, number of array rows fed.
- REQ-002: The module SHALL have one clock; reset is synchronous and active-high.
- REQ-003: clk  input  1  rising-edge clock.
- REQ-004: reset  input  1  synchronous active-high reset.
- REQ-005: start  input  1  job start pulse, sampled in IDLE only.
- REQ-006: vec_count  input  16  number of activation vectors in the job, latched on accepted start.
- REQ-007: w_valid  input  1  weight beat valid.
- REQ-008: w_ready  output  1  weight beat accepted when w_valid and w_ready are both high.
- REQ-009: w_data  input  WORDWIDTH+1  weight word broadcast to the array.
- REQ-010: a_valid  input  1  activation vector valid.
- REQ-011: a_ready  output  1  activation vector accepted when a_valid and a_ready are both high.
- REQ-012: a_data  input  ROWS*(WORDWIDTH+1)  activation vector; row r occupies bits [r*(WORDWIDTH+1) +: WORDWIDTH+1].
- REQ-013: mode_out  output  1  PE mode: 0 = PEMODE_WL (weight load), 1 = PEMODE_PS (partial-sum compute).
- REQ-014: w_out  output  WORDWIDTH+1  weight to PE w_in.
- REQ-015: a_out  output  ROWS*(WORDWIDTH+1)  skewed activations to PE a_in, same packing as a_data.
- REQ-016: busy  output  1  high in every state except IDLE.
- REQ-017: done  output  1  single-cycle job-complete pulse.

Function
- REQ-018: The FSM SHALL have the states IDLE, LOAD_W, COMPUTE, DRAIN, and DONE; every output SHALL be registered.
- REQ-019: IDLE: start=1 SHALL latch vec_count into a remaining-count register and go to LOAD_W; start in any other state SHALL be ignored.
- REQ-020: LOAD_W: w_ready=1; on w_valid, the next cycle SHALL show mode_out=0 and w_out=w_data for exactly one cycle; the FSM then goes to COMPUTE, or to DRAIN if the latched count is 0.
- REQ-021: In every state except the weight-load output cycle, mode_out SHALL be 1 and w_out SHALL hold its last value.
- REQ-022: COMPUTE: a_ready=1; each accepted vector SHALL decrement the remaining count; after the vector that brings the count to 0 is accepted, the FSM goes to DRAIN and a_ready drops in the same cycle as the state change.
- REQ-023: Skew: row r of an accepted vector (accept edge t) SHALL appear on a_out row r at cycle t+1+r; row 0 has 1-cycle latency; the skew pipeline shifts every cycle in all states.
- REQ-024: A cycle in COMPUTE without a handshake (bubble) SHALL inject zero into row 0 of the skew pipeline, so the PE accumulates +0.
- REQ-025: DRAIN SHALL last exactly ROWS-1 cycles and inject zeros, so that the last vector's row ROWS-1 reaches a_out; the FSM then goes to DONE.
- REQ-026: DONE SHALL assert done=1 for one cycle, then return to IDLE; busy SHALL fall in the same cycle that done falls.
- REQ-027: In IDLE, a_out rows SHALL be zero once the pipeline has drained; w_ready=a_ready=0 in all states other than those named above.
- REQ-028: vec_count=0xFFFF SHALL be supported without wrap (16-bit down-counter that stops at 0).

Reset
- REQ-029: With reset=1 at a clock edge, the state SHALL be IDLE, mode_out=1, w_out=0, all a_out rows 0, the skew pipeline 0, the remaining count 0, w_ready=a_ready=busy=done=0.
- REQ-030: Reset mid-job SHALL abort the job with no done pulse; the next start SHALL run a full job normally.

Verification
- REQ-031: ROWS=4; start with vec_count=2, w_data=5, then vectors {1,2,3,4} and {5,6,7,8} back-to-back -> one cycle with mode_out=0/w_out=5; row0 shows 1,5; row3 shows 4,8 three cycles later; done occurs 1 cycle after DRAIN's 3 cycles.
- REQ-032: Same job with one a_valid=0 cycle between the vectors -> a zero word appears between the values on each row, shifted by r per row.
- REQ-033: vec_count=0 -> weight load, then 3 DRAIN cycles, then done; a_ready is never high.
- REQ-034: Assert start while busy -> no effect; remaining count unchanged.
- REQ-035: Assert reset during COMPUTE after 1 of 3 vectors -> next cycle all outputs equal their REQ-029 values; no done pulse.
- REQ-036: Withhold w_valid for 10 cycles in LOAD_W -> mode_out stays 1, a_ready stays 0, and no state advance.
